// File: rtl/board_render.sv
`default_nettype none
// ============================================================================
//  Module   : board_render
//  Purpose  : Active-video pixel renderer for the board display. Tracks the
//             pixel position from the hen/ven active-video enables, draws an
//             N x N checkerboard at a parametrised origin and cell size,
//             fetches one piece code per cell from the board-state RAM and
//             overlays round pieces and a blinking cursor outline.
//  Ports    : pclk       - pixel clock, all logic on its rising edge
//             rst        - synchronous active-high reset
//             hen, ven   - horizontal / vertical active-video enables
//             mode       - 0 board, 1 +pieces, 2 +pieces+cursor, 3 solid C_BG
//             cur_x/y    - cursor cell column / row (>= N draws no cursor)
//             raddr      - board RAM address, row*N + col
//             rdata      - piece code, valid one pclk after raddr
//             rgb        - RGB444 pixel colour, 3 pclk after the pixel enable
//             frame_tick - one-cycle pulse for the last active pixel of a frame
//  Revision : 1.0 - initial release
// ============================================================================
module board_render #(
    parameter int          H_ACT   = 800,
    parameter int          V_ACT   = 600,
    parameter int          ORG_X   = 60,
    parameter int          ORG_Y   = 60,
    parameter int          CELL    = 60,
    parameter int          N       = 8,
    parameter int          RAD     = 24,
    parameter int          BLINK   = 5,
    parameter logic [11:0] C_LIGHT = 12'hFEA,
    parameter logic [11:0] C_DARK  = 12'h777,
    parameter logic [11:0] C_BG    = 12'h000,
    parameter logic [11:0] C_P1    = 12'h000,
    parameter logic [11:0] C_P2    = 12'hFFF,
    parameter logic [11:0] C_HL    = 12'h0F0,
    parameter logic [11:0] C_CUR   = 12'hF00
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        hen,
    input  logic        ven,
    input  logic [1:0]  mode,
    input  logic [3:0]  cur_x,
    input  logic [3:0]  cur_y,
    output logic [7:0]  raddr,
    input  logic [1:0]  rdata,
    output logic [11:0] rgb,
    output logic        frame_tick
);

    localparam logic [9:0]  c_x_last    = 10'(H_ACT - 1);
    localparam logic [9:0]  c_y_last    = 10'(V_ACT - 1);
    localparam logic [9:0]  c_org_x     = 10'(ORG_X);
    localparam logic [9:0]  c_org_y     = 10'(ORG_Y);
    localparam logic [7:0]  c_cell_last = 8'(CELL - 1);
    localparam logic [7:0]  c_half      = 8'(CELL / 2);
    localparam logic [7:0]  c_edge_hi   = 8'(CELL - 2);
    localparam logic [3:0]  c_n_last    = 4'(N - 1);
    localparam logic [7:0]  c_n         = 8'(N);
    localparam logic [15:0] c_rad_sq    = 16'(RAD * RAD);
    localparam logic        c_x_in0     = (ORG_X == 0);
    localparam logic        c_y_in0     = (ORG_Y == 0);

    // Per-axis cell tracker: in-cell offset, cell index, inside-board flag.
    typedef struct packed {
        logic [7:0] o;
        logic [3:0] c;
        logic       in;
    } axis_t;

    // Advances one axis tracker alongside its position counter, so cell
    // index and offset are available without any divider.
    function automatic axis_t axis_next(input axis_t cur, input logic zero,
                                        input logic step, input logic hit_org,
                                        input logic start_in);
        axis_t nxt;
        nxt = cur;
        if (zero) begin
            nxt.o  = '0;
            nxt.c  = '0;
            nxt.in = start_in;
        end else if (step) begin
            if (hit_org) begin
                nxt.o  = '0;
                nxt.c  = '0;
                nxt.in = 1'b1;
            end else if (cur.in) begin
                if (cur.o == c_cell_last) begin
                    nxt.o = '0;
                    if (cur.c == c_n_last) begin
                        nxt.in = 1'b0;
                    end else begin
                        nxt.c = cur.c + 4'd1;
                    end
                end else begin
                    nxt.o = cur.o + 8'd1;
                end
            end
        end
        return nxt;
    endfunction

    // Stage 0: position counters and cell trackers
    logic [9:0]  x_q, x_d, y_q, y_d;
    axis_t       xc_q, xc_d, yc_q, yc_d;
    logic        frame_tick_q, frame_tick_d;
    // Stage 1
    logic        s1_valid_q, s1_valid_d, s1_inb_q, s1_inb_d;
    logic [3:0]  s1_cx_q, s1_cx_d, s1_cy_q, s1_cy_d;
    logic [7:0]  s1_ox_q, s1_ox_d, s1_oy_q, s1_oy_d;
    logic [7:0]  raddr_q, raddr_d;
    // Stage 2
    logic        s2_valid_q, s2_valid_d, s2_inb_q, s2_inb_d;
    logic [3:0]  s2_cx_q, s2_cx_d, s2_cy_q, s2_cy_d;
    logic        s2_piece_q, s2_piece_d, s2_edge_q, s2_edge_d;
    logic        s2_par_q, s2_par_d;
    // Stage 3 and blink
    logic [11:0] rgb_q, rgb_d;
    logic [BLINK:0] blink_cnt_q, blink_cnt_d;

    logic        w_act, w_x_wrap, w_y_wrap, w_inb;
    logic        w_step_x, w_zero_x, w_step_y, w_zero_y;
    logic signed [7:0]  w_dx, w_dy;
    logic signed [15:0] w_dx_sq, w_dy_sq;
    logic [15:0] w_dist_sq;
    logic        w_blink, w_cur_hit;

    assign w_act    = hen & ven;
    assign w_x_wrap = (x_q == c_x_last);
    assign w_y_wrap = (y_q == c_y_last);
    assign w_step_x = w_act & ~w_x_wrap;
    assign w_zero_x = ~ven | (w_act & w_x_wrap);
    assign w_step_y = w_act & w_x_wrap & ~w_y_wrap;
    assign w_zero_y = ~ven | (w_act & w_x_wrap & w_y_wrap);
    assign w_inb    = xc_q.in & yc_q.in;

    // Distance of the pixel from the cell centre, squared in 16 bits.
    assign w_dx      = signed'(s1_ox_q - c_half);
    assign w_dy      = signed'(s1_oy_q - c_half);
    assign w_dx_sq   = $signed({{8{w_dx[7]}}, w_dx}) * $signed({{8{w_dx[7]}}, w_dx});
    assign w_dy_sq   = $signed({{8{w_dy[7]}}, w_dy}) * $signed({{8{w_dy[7]}}, w_dy});
    assign w_dist_sq = unsigned'(w_dx_sq) + unsigned'(w_dy_sq);

    // Top counter bit flips once every 2^BLINK frame ticks.
    assign w_blink   = blink_cnt_q[BLINK];
    assign w_cur_hit = (mode == 2'd2) && (s2_cx_q == cur_x) && (s2_cy_q == cur_y)
                       && s2_edge_q && w_blink;

    always_comb begin
        // Stage 0
        x_d = x_q;
        y_d = y_q;
        if (w_zero_x)      x_d = '0;
        else if (w_step_x) x_d = x_q + 10'd1;
        if (w_zero_y)      y_d = '0;
        else if (w_step_y) y_d = y_q + 10'd1;
        xc_d = axis_next(xc_q, w_zero_x, w_step_x, (x_q + 10'd1) == c_org_x, c_x_in0);
        yc_d = axis_next(yc_q, w_zero_y, w_step_y, (y_q + 10'd1) == c_org_y, c_y_in0);
        frame_tick_d = w_act & w_x_wrap & w_y_wrap;

        // Stage 1: raddr only moves for in-board active pixels
        s1_valid_d = w_act;
        s1_inb_d   = w_inb;
        s1_cx_d    = xc_q.c;
        s1_cy_d    = yc_q.c;
        s1_ox_d    = xc_q.o;
        s1_oy_d    = yc_q.o;
        raddr_d    = raddr_q;
        if (w_act && w_inb) begin
            raddr_d = {4'd0, yc_q.c} * c_n + {4'd0, xc_q.c};
        end

        // Stage 2: geometry, rdata is looked up in the colour mux below
        s2_valid_d = s1_valid_q;
        s2_inb_d   = s1_inb_q;
        s2_cx_d    = s1_cx_q;
        s2_cy_d    = s1_cy_q;
        s2_piece_d = (w_dist_sq < c_rad_sq);
        s2_edge_d  = (s1_ox_q < 8'd2) || (s1_ox_q >= c_edge_hi) ||
                     (s1_oy_q < 8'd2) || (s1_oy_q >= c_edge_hi);
        s2_par_d   = s1_cx_q[0] ^ s1_cy_q[0];

        // Stage 3: colour priority mux
        if (!s2_valid_q) begin
            rgb_d = 12'h000;
        end else if (mode == 2'd3 || !s2_inb_q) begin
            rgb_d = C_BG;
        end else if (w_cur_hit) begin
            rgb_d = C_CUR;
        end else if (mode != 2'd0 && s2_piece_q && rdata != 2'd0) begin
            case (rdata)
                2'd1:    rgb_d = C_P1;
                2'd2:    rgb_d = C_P2;
                default: rgb_d = C_HL;
            endcase
        end else begin
            rgb_d = s2_par_q ? C_DARK : C_LIGHT;
        end

        blink_cnt_d = frame_tick_q ? blink_cnt_q + 1'b1 : blink_cnt_q;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            xc_q         <= '{o: 8'd0, c: 4'd0, in: c_x_in0};
            yc_q         <= '{o: 8'd0, c: 4'd0, in: c_y_in0};
            frame_tick_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_inb_q     <= 1'b0;
            s1_cx_q      <= '0;
            s1_cy_q      <= '0;
            s1_ox_q      <= '0;
            s1_oy_q      <= '0;
            raddr_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_inb_q     <= 1'b0;
            s2_cx_q      <= '0;
            s2_cy_q      <= '0;
            s2_piece_q   <= 1'b0;
            s2_edge_q    <= 1'b0;
            s2_par_q     <= 1'b0;
            rgb_q        <= 12'h000;
            blink_cnt_q  <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            xc_q         <= xc_d;
            yc_q         <= yc_d;
            frame_tick_q <= frame_tick_d;
            s1_valid_q   <= s1_valid_d;
            s1_inb_q     <= s1_inb_d;
            s1_cx_q      <= s1_cx_d;
            s1_cy_q      <= s1_cy_d;
            s1_ox_q      <= s1_ox_d;
            s1_oy_q      <= s1_oy_d;
            raddr_q      <= raddr_d;
            s2_valid_q   <= s2_valid_d;
            s2_inb_q     <= s2_inb_d;
            s2_cx_q      <= s2_cx_d;
            s2_cy_q      <= s2_cy_d;
            s2_piece_q   <= s2_piece_d;
            s2_edge_q    <= s2_edge_d;
            s2_par_q     <= s2_par_d;
            rgb_q        <= rgb_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    assign raddr      = raddr_q;
    assign rgb        = rgb_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_board_render.sv
`default_nettype none
// ============================================================================
//  Module   : tb_board_render
//  Purpose  : Self-checking bench for board_render. A reference model computes
//             each pixel colour from screen coordinates with plain division
//             and modulo, queues the expected rgb/raddr/frame_tick per cycle,
//             and a monitor compares them against the DUT outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_board_render;

    localparam int H  = 48;
    localparam int V  = 40;
    localparam int OX = 5;
    localparam int OY = 3;
    localparam int CL = 8;
    localparam int NN = 4;
    localparam int RD = 3;
    localparam int BL = 1;
    localparam logic [11:0] K_LIGHT = 12'hFEA;
    localparam logic [11:0] K_DARK  = 12'h777;
    localparam logic [11:0] K_BG    = 12'h123;
    localparam logic [11:0] K_P1    = 12'h456;
    localparam logic [11:0] K_P2    = 12'hFFF;
    localparam logic [11:0] K_HL    = 12'h0F0;
    localparam logic [11:0] K_CUR   = 12'hF00;

    logic        pclk = 1'b0;
    logic        rst, hen, ven;
    logic [1:0]  mode;
    logic [3:0]  cur_x, cur_y;
    logic [7:0]  raddr;
    logic [1:0]  rdata;
    logic [11:0] rgb;
    logic        frame_tick;

    board_render #(
        .H_ACT(H), .V_ACT(V), .ORG_X(OX), .ORG_Y(OY), .CELL(CL), .N(NN),
        .RAD(RD), .BLINK(BL), .C_LIGHT(K_LIGHT), .C_DARK(K_DARK), .C_BG(K_BG),
        .C_P1(K_P1), .C_P2(K_P2), .C_HL(K_HL), .C_CUR(K_CUR)
    ) dut (
        .pclk(pclk), .rst(rst), .hen(hen), .ven(ven), .mode(mode),
        .cur_x(cur_x), .cur_y(cur_y), .raddr(raddr), .rdata(rdata),
        .rgb(rgb), .frame_tick(frame_tick)
    );

    always #5 pclk = ~pclk;

    // Board-state RAM with one-cycle read latency
    logic [1:0] ram [0:255];
    always @(posedge pclk) rdata <= ram[raddr];

    typedef struct packed {
        logic [11:0] rgb;
        logic [7:0]  raddr;
        logic        ft;
    } exp_t;

    exp_t q[$];
    exp_t got;
    int   vectors     = 0;
    int   miscompares = 0;

    // Model state: screen position and short histories of past cycles
    int mx = 0, my = 0;
    bit pv_d1 = 0, pv_d2 = 0, rst_d1 = 0, ft_prev = 0;
    int px_d1 = 0, py_d1 = 0, px_d2 = 0, py_d2 = 0;
    int raddr_d1 = 0, raddr_d2 = 0, cnt_prev = 0;

    function automatic bit on_board(input int x, input int y);
        return (x >= OX) && (x < OX + NN * CL) && (y >= OY) && (y < OY + NN * CL);
    endfunction

    function automatic logic [11:0] colour(input int x, input int y,
                                           input logic [1:0] md, input int ux,
                                           input int uy, input bit blk,
                                           input logic [1:0] code);
        int cx, cy, ox, oy, dx, dy;
        bit edge_px, piece;
        if (md == 2'd3 || !on_board(x, y)) return K_BG;
        cx = (x - OX) / CL;
        cy = (y - OY) / CL;
        ox = (x - OX) % CL;
        oy = (y - OY) % CL;
        dx = ox - CL / 2;
        dy = oy - CL / 2;
        edge_px = (ox < 2) || (ox >= CL - 2) || (oy < 2) || (oy >= CL - 2);
        piece   = (dx * dx + dy * dy) < RD * RD;
        if (md == 2'd2 && cx == ux && cy == uy && edge_px && blk) return K_CUR;
        if (md != 2'd0 && piece && code != 2'd0) begin
            if (code == 2'd1) return K_P1;
            if (code == 2'd2) return K_P2;
            return K_HL;
        end
        return ((cx + cy) % 2 == 0) ? K_LIGHT : K_DARK;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after its edge
    task automatic step(input bit r, input bit h, input bit v,
                        input logic [1:0] md, input logic [3:0] ux,
                        input logic [3:0] uy);
        bit   pv, inb, ft, blk;
        int   px, py, ra, cnt;
        exp_t e;
        @(negedge pclk);
        rst = r; hen = h; ven = v; mode = md; cur_x = ux; cur_y = uy;
        pv  = !r && h && v;
        px  = mx;
        py  = my;
        if (r || !v) begin
            mx = 0;
            my = 0;
        end else if (h) begin
            if (mx == H - 1) begin
                mx = 0;
                my = (my == V - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        inb = on_board(px, py);
        ft  = pv && px == H - 1 && py == V - 1;
        ra  = r ? 0 : ((pv && inb) ? ((py - OY) / CL) * NN + (px - OX) / CL : raddr_d1);
        cnt = r ? 0 : cnt_prev + int'(ft_prev);
        blk = ((cnt_prev >> BL) & 1) == 1;
        e.rgb   = (r || rst_d1 || !pv_d2) ? 12'h000 :
                  colour(px_d2, py_d2, md, int'(ux), int'(uy), blk, ram[raddr_d2[7:0]]);
        e.raddr = ra[7:0];
        e.ft    = ft;
        q.push_back(e);
        ft_prev  = ft;
        cnt_prev = cnt;
        raddr_d2 = raddr_d1;
        raddr_d1 = ra;
        pv_d2 = pv_d1;  pv_d1 = pv;
        px_d2 = px_d1;  px_d1 = px;
        py_d2 = py_d1;  py_d1 = py;
        rst_d1 = r;
    endtask

    // Monitor: compares each registered output set just after its edge
    always @(posedge pclk) begin
        #1;
        if (q.size() > 0) begin
            got = q.pop_front();
            vectors++;
            if (rgb !== got.rgb || raddr !== got.raddr || frame_tick !== got.ft) begin
                miscompares++;
                $display("FAIL pixel vec %0d t=%0t: rgb=%h raddr=%0d frame_tick=%b, expected rgb=%h raddr=%0d frame_tick=%b",
                         vectors, $time, rgb, raddr, frame_tick, got.rgb, got.raddr, got.ft);
            end
        end
    end

    initial begin
        logic [1:0] md;
        logic [3:0] ux, uy;
        int vl;
        rst = 1'b1; hen = 1'b0; ven = 1'b0; mode = 2'd0; cur_x = 4'd0; cur_y = 4'd0;
        for (int i = 0; i < 256; i++) ram[i] = 2'd0;

        // Reset, then a full frame of plain board
        repeat (3) step(1, 0, 0, 2'd0, 4'd0, 4'd0);
        repeat (H * V + 10) step(0, 1, 1, 2'd0, 4'd0, 4'd0);

        // New RAM contents loaded under reset, then a frame with pieces
        for (int i = 0; i < 256; i++) ram[i] = 2'($urandom_range(0, 3));
        ram[0] = 2'd2;
        ram[NN + 1] = 2'd1;
        repeat (4) step(1, 0, 0, 2'd1, 4'd0, 4'd0);
        repeat (H * V + 10) step(0, 1, 1, 2'd1, 4'd0, 4'd0);

        // Cursor mode over several frames so the blink state toggles
        ux = 4'd3; uy = 4'd0;
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                ux = 4'($urandom_range(0, 5));
                uy = 4'($urandom_range(0, 5));
            end
            step(0, $urandom_range(0, 3) != 0, 1, 2'd2, ux, uy);
        end

        // hen toggling every other cycle
        for (int i = 0; i < 600; i++) step(0, (i % 2) == 1, 1, 2'd2, 4'd1, 4'd1);

        // Random blanking, mode changes and occasional reset pulses
        vl = 0;
        md = 2'd2;
        for (int i = 0; i < 8000; i++) begin
            if (vl == 0 && $urandom_range(0, 399) == 0) vl = $urandom_range(1, 40);
            if ($urandom_range(0, 299) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                ux = 4'($urandom_range(0, 15));
                uy = 4'($urandom_range(0, 15));
            end
            step($urandom_range(0, 1499) == 0, $urandom_range(0, 3) != 0, vl == 0, md, ux, uy);
            if (vl > 0) vl--;
        end

        // Reset right in the middle of the board, then restart from (0,0)
        for (int i = 0; i < 5000 && !(mx == 20 && my == 20); i++)
            step(0, 1, 1, 2'd2, 4'd1, 4'd2);
        step(1, 1, 1, 2'd2, 4'd1, 4'd2);
        repeat (H * 6) step(0, 1, 1, 2'd1, 4'd1, 4'd2);

        repeat (3) step(0, 0, 0, 2'd0, 4'd0, 4'd0);
        @(posedge pclk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
